counter_sequencer: RTL and testbench

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

---
 rtl/counter_sequencer_if.sv | 48 ++++
 rtl/counter_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_counter_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/counter_sequencer_if.sv
// counter_sequencer_if -- signal bundle between the sequencer and its environment.
//
// Groups the request side (start/start_val/target/pause), the external up/down counter
// side (cnt_value in; ld_cnt/updn_cnt/count_enb/load_val out) and the status outputs
// (busy/done/steps, plus err when SEQ_STALL_DET_EN is defined).
//
// Modports:
//   master : environment view (drives requests and counter feedback, observes the rest)
//   slave  : sequencer view (counter_sequencer uses this one)
//
// Optional feature macro: SEQ_STALL_DET_EN (adds the err signal).
interface counter_sequencer_if;
  logic        start;
  logic [15:0] start_val;
  logic [15:0] target;
  logic        pause;
  logic [15:0] cnt_value;
  logic        ld_cnt;
  logic        updn_cnt;
  logic        count_enb;
  logic [15:0] load_val;
  logic        busy;
  logic        done;
  logic [15:0] steps;
`ifdef SEQ_STALL_DET_EN
  logic        err;

  modport master (
    output start, start_val, target, pause, cnt_value,
    input  ld_cnt, updn_cnt, count_enb, load_val, busy, done, steps, err
  );

  modport slave (
    input  start, start_val, target, pause, cnt_value,
    output ld_cnt, updn_cnt, count_enb, load_val, busy, done, steps, err
  );
`else
  modport master (
    output start, start_val, target, pause, cnt_value,
    input  ld_cnt, updn_cnt, count_enb, load_val, busy, done, steps
  );

  modport slave (
    input  start, start_val, target, pause, cnt_value,
    output ld_cnt, updn_cnt, count_enb, load_val, busy, done, steps
  );
`endif
endinterface

// File: rtl/counter_sequencer.sv
// counter_sequencer -- drives an external up/down counter from start_val to target.
//
// Sequence: IDLE -> LOAD -> SETTLE -> RUN -> DONE -> IDLE, one edge per transition.
//   LOAD   : ld_cnt low for one cycle, counter loads load_val (captured start_val).
//   SETTLE : one quiet cycle so the loaded value appears on cnt_value.
//   RUN    : count_enb/updn_cnt are combinational from cnt_value, captured target and
//            pause; leaves on the first edge where cnt_value equals target.
//   DONE   : one-cycle done pulse; steps holds the number of enabled cycles.
//
// Ports:
//   clk  : system clock, rising edge
//   rst_ : synchronous active-high reset
//   bus  : counter_sequencer_if.slave (request, counter and status signals)
//
// Optional feature macro: SEQ_STALL_DET_EN. When defined, 4 consecutive enabled RUN
// cycles with cnt_value unchanged set err and end the run. When undefined, err and the
// stall logic do not exist and RUN waits for the target indefinitely.
module counter_sequencer (
  input logic               clk,
  input logic               rst_,
  counter_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSettle,
    StRun,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] load_val_q, load_val_d;
  logic [15:0] target_q, target_d;
  logic [15:0] steps_q, steps_d;

  logic        accept;
  logic        at_target;
  logic        stall_hit;
  logic        ld_cnt;
  logic        updn_cnt;
  logic        count_enb;
  logic        busy;
  logic        done;

  // start is only honoured in IDLE; reset priority in the flops discards a start
  // that coincides with rst_.
  assign accept    = (state_q == StIdle) && bus.start;
  assign at_target = (bus.cnt_value == target_q);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.start) state_d = StLoad;
      StLoad:   state_d = StSettle;
      StSettle: state_d = StRun;
      // Completion wins even when pause is high on the matching cycle.
      StRun:    if (at_target || stall_hit) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    ld_cnt    = 1'b1;
    updn_cnt  = 1'b0;
    count_enb = 1'b0;
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    if (state_q == StLoad) begin
      ld_cnt = 1'b0;
    end
    if (state_q == StRun) begin
      count_enb = !at_target && !bus.pause;
      // Plain unsigned magnitude compare: direction never depends on wrap-around.
      updn_cnt  = (target_q > bus.cnt_value);
    end
  end

  // ---------------------------------------------------------------------------
  // Captured operands and step counter
  // ---------------------------------------------------------------------------
  always_comb begin
    load_val_d = load_val_q;
    target_d   = target_q;
    steps_d    = steps_q;
    if (accept) begin
      load_val_d = bus.start_val;
      target_d   = bus.target;
      steps_d    = '0;
    end else if (count_enb) begin
      steps_d = steps_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      load_val_q <= '0;
      target_q   <= '0;
      steps_q    <= '0;
    end else begin
      load_val_q <= load_val_d;
      target_q   <= target_d;
      steps_q    <= steps_d;
    end
  end

`ifdef SEQ_STALL_DET_EN
  // ---------------------------------------------------------------------------
  // Stall detector: counts consecutive enabled RUN cycles that see the same
  // cnt_value. The first enabled cycle of a streak always counts as 1.
  // ---------------------------------------------------------------------------
  logic [2:0]  stall_cnt_q, stall_cnt_d;
  logic [15:0] stall_val_q, stall_val_d;
  logic        err_q, err_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    stall_val_d = stall_val_q;
    stall_hit   = 1'b0;
    if ((state_q != StRun) || !count_enb) begin
      stall_cnt_d = '0;
    end else begin
      stall_val_d = bus.cnt_value;
      if ((stall_cnt_q == '0) || (bus.cnt_value != stall_val_q)) begin
        stall_cnt_d = 3'd1;
      end else begin
        stall_cnt_d = stall_cnt_q + 3'd1;
      end
      stall_hit = (stall_cnt_d == 3'd4);
    end
  end

  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = 1'b0;
    end else if (stall_hit) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      stall_cnt_q <= '0;
      stall_val_q <= '0;
      err_q       <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      stall_val_q <= stall_val_d;
      err_q       <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign stall_hit = 1'b0;
`endif

  assign bus.ld_cnt    = ld_cnt;
  assign bus.updn_cnt  = updn_cnt;
  assign bus.count_enb = count_enb;
  assign bus.load_val  = load_val_q;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.steps     = steps_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer paired with a behavioural up/down counter.
// Expected results come from the run arithmetic: a run from s to t takes |t-s| enabled
// cycles, one load cycle, and completes 4 + |t-s| + paused cycles after the start edge.
module tb_counter_sequencer;

  logic clk = 1'b0;
  logic rst_;
  always #5 clk = ~clk;

  counter_sequencer_if bus ();

  counter_sequencer u_dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  // Behavioural counter: active-low synchronous load, enable, direction.
  // 'stuck' freezes counting (loads still work) to emulate a broken counter.
  logic [15:0] cnt_model = 16'h0000;
  bit          stuck     = 1'b0;
  assign bus.cnt_value = cnt_model;

  always @(posedge clk) begin
    if (!bus.ld_cnt) begin
      cnt_model <= bus.load_val;
    end else if (bus.count_enb && !stuck) begin
      cnt_model <= bus.updn_cnt ? cnt_model + 16'd1 : cnt_model - 16'd1;
    end
  end

  int n_total = 0;
  int n_pass  = 0;

  // One complete run. k counts edges from the accepting edge (k=1 is LOAD).
  // Pause is held for p_len cycles starting at k=4 (inside counting when |t-s| >= 2).
  task automatic run_seq(input string name, input logic [15:0] s, input logic [15:0] t,
                         input int p_len, input bit extra_start);
    int          si, ti, d, exp_lat, lat, k;
    int          ld_low, enb, updn_bad, busy_bad, steps_p0, steps_p1;
    logic [15:0] steps_done, cnt_done, lv_done;
    logic        updn_exp;
    si = int'(s);
    ti = int'(t);
    d = (si > ti) ? si - ti : ti - si;
    exp_lat = 4 + d + p_len;
    updn_exp = (ti > si);
    lat = -1; ld_low = 0; enb = 0; updn_bad = 0; busy_bad = 0;
    steps_p0 = -1; steps_p1 = -1;
    steps_done = '0; cnt_done = '0; lv_done = '0;

    @(negedge clk);
    bus.start = 1'b1; bus.start_val = s; bus.target = t; bus.pause = 1'b0;
    @(posedge clk); #1;
    k = 1;
    // Scramble inputs after acceptance: the DUT must use its captured copies.
    bus.start_val = 16'($urandom);
    bus.target    = 16'($urandom);
    while (lat < 0 && k < 300) begin
      bus.pause = (k >= 4) && (k < 4 + p_len);
      bus.start = extra_start && (k == 2);
      #1;
      if (!bus.ld_cnt) ld_low++;
      if (!bus.busy) busy_bad++;
      if (bus.count_enb) begin
        enb++;
        if (bus.updn_cnt !== updn_exp) updn_bad++;
      end
      if ((k <= 2 || bus.done) && bus.updn_cnt !== 1'b0) updn_bad++;
      if (p_len > 0 && k == 4) steps_p0 = int'(bus.steps);
      if (p_len > 0 && k == 4 + p_len) steps_p1 = int'(bus.steps);
      if (bus.done) begin
        lat = k; steps_done = bus.steps; cnt_done = bus.cnt_value; lv_done = bus.load_val;
      end else begin
        @(posedge clk); #1;
        k++;
      end
    end
    bus.pause = 1'b0;
    bus.start = 1'b0;

    n_total++; if (lat !== exp_lat) $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat); else n_pass++;
    n_total++; if (ld_low !== 1) $display("FAIL %s ld_cnt_low_cycles: got %0d want 1", name, ld_low); else n_pass++;
    n_total++; if (enb !== d) $display("FAIL %s enabled_cycles: got %0d want %0d", name, enb, d); else n_pass++;
    n_total++; if (updn_bad !== 0) $display("FAIL %s updn_cnt: %0d bad cycles want 0", name, updn_bad); else n_pass++;
    n_total++; if (busy_bad !== 0) $display("FAIL %s busy: %0d low cycles while running want 0", name, busy_bad); else n_pass++;
    n_total++; if (steps_done !== 16'(d)) $display("FAIL %s steps: got %0d want %0d", name, steps_done, d); else n_pass++;
    n_total++; if (cnt_done !== t) $display("FAIL %s cnt_value: got %h want %h", name, cnt_done, t); else n_pass++;
    n_total++; if (lv_done !== s) $display("FAIL %s load_val: got %h want %h", name, lv_done, s); else n_pass++;
    if (p_len > 0) begin
      n_total++; if (steps_p0 !== steps_p1) $display("FAIL %s steps_frozen: got %0d then %0d want equal", name, steps_p0, steps_p1); else n_pass++;
    end
`ifdef SEQ_STALL_DET_EN
    n_total++; if (bus.err !== 1'b0) $display("FAIL %s err: got %b want 0", name, bus.err); else n_pass++;
`endif
    @(posedge clk); #1;
    n_total++; if ({bus.done, bus.busy} !== 2'b00) $display("FAIL %s after_done: done,busy got %b want 00", name, {bus.done, bus.busy}); else n_pass++;
    n_total++; if (bus.steps !== 16'(d)) $display("FAIL %s steps_hold: got %0d want %0d", name, bus.steps, d); else n_pass++;
  endtask

  task automatic test_reset();
    // start held high together with reset must not be accepted.
    rst_ = 1'b1; bus.start = 1'b1; bus.start_val = 16'h1234; bus.target = 16'h5678;
    bus.pause = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (bus.ld_cnt !== 1'b1) $display("FAIL reset ld_cnt: got %b want 1", bus.ld_cnt); else n_pass++;
    n_total++; if ({bus.updn_cnt, bus.count_enb} !== 2'b00) $display("FAIL reset updn,enb: got %b want 00", {bus.updn_cnt, bus.count_enb}); else n_pass++;
    n_total++; if (bus.load_val !== 16'h0) $display("FAIL reset load_val: got %h want 0000", bus.load_val); else n_pass++;
    n_total++; if ({bus.busy, bus.done} !== 2'b00) $display("FAIL reset busy,done: got %b want 00", {bus.busy, bus.done}); else n_pass++;
    n_total++; if (bus.steps !== 16'h0) $display("FAIL reset steps: got %0d want 0", bus.steps); else n_pass++;
`ifdef SEQ_STALL_DET_EN
    n_total++; if (bus.err !== 1'b0) $display("FAIL reset err: got %b want 0", bus.err); else n_pass++;
`endif
    bus.start = 1'b0; rst_ = 1'b0;
    @(posedge clk); #1;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset start_ignored busy: got %b want 0", bus.busy); else n_pass++;
  endtask

  task automatic test_count_up();
    run_seq("count_up", 16'h0010, 16'h0014, 0, 1'b0);
  endtask

  task automatic test_count_down();
    run_seq("count_down", 16'hABCD, 16'hABC8, 0, 1'b0);
  endtask

  task automatic test_pause();
    run_seq("pause", 16'h0010, 16'h0014, 3, 1'b0);
  endtask

  task automatic test_reset_in_run();
    logic mid_enb;
    @(negedge clk);
    bus.start = 1'b1; bus.start_val = 16'h0100; bus.target = 16'h0120;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    mid_enb = bus.count_enb;
    n_total++; if (mid_enb !== 1'b1) $display("FAIL rst_in_run counting_before: got %b want 1", mid_enb); else n_pass++;
    rst_ = 1'b1;
    @(posedge clk); #1;
    rst_ = 1'b0;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL rst_in_run busy: got %b want 0", bus.busy); else n_pass++;
    n_total++; if (bus.count_enb !== 1'b0) $display("FAIL rst_in_run count_enb: got %b want 0", bus.count_enb); else n_pass++;
    n_total++; if (bus.steps !== 16'h0) $display("FAIL rst_in_run steps: got %0d want 0", bus.steps); else n_pass++;
    run_seq("rst_rerun", 16'h0000, 16'h0002, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_seq("equal_ignored_start", 16'h5A5A, 16'h5A5A, 0, 1'b1);
    run_seq("ignored_start_up", 16'h0020, 16'h0026, 0, 1'b1);
    // Sign-bit crossings: a signed compare or wrap-based direction would go wrong.
    run_seq("cross_down", 16'h8000, 16'h7FFE, 1, 1'b0);
    run_seq("cross_up", 16'h7FFF, 16'h8001, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      logic [15:0] s, t;
      int          delta, ti, p;
      s = 16'($urandom);
      delta = int'($urandom_range(0, 24));
      ti = ($urandom_range(0, 1) == 1) ? int'(s) + delta : int'(s) - delta;
      if (ti > 65535 || ti < 0) ti = (ti > 65535) ? int'(s) - delta : int'(s) + delta;
      t = 16'(ti);
      p = (delta >= 2) ? int'($urandom_range(0, 3)) : 0;
      run_seq($sformatf("random%0d", i), s, t, p, 1'($urandom_range(0, 1)));
    end
  endtask

`ifdef SEQ_STALL_DET_EN
  task automatic test_stall();
    int lat, k;
    logic [15:0] st;
    stuck = 1'b1;
    lat = -1;
    st = '0;
    @(negedge clk);
    bus.start = 1'b1; bus.start_val = 16'h0010; bus.target = 16'h0020;
    @(posedge clk); #1;
    bus.start = 1'b0;
    k = 1;
    while (lat < 0 && k < 100) begin
      #1;
      if (bus.done) begin
        lat = k; st = bus.steps;
        n_total++; if (bus.err !== 1'b1) $display("FAIL stall err: got %b want 1", bus.err); else n_pass++;
      end else begin
        @(posedge clk); #1;
        k++;
      end
    end
    // LOAD, SETTLE, four enabled RUN cycles, then DONE.
    n_total++; if (lat !== 7) $display("FAIL stall latency: got %0d want 7", lat); else n_pass++;
    n_total++; if (st !== 16'd4) $display("FAIL stall steps: got %0d want 4", st); else n_pass++;
    stuck = 1'b0;
    @(posedge clk); #1;
    n_total++; if (bus.err !== 1'b1) $display("FAIL stall err_hold: got %b want 1", bus.err); else n_pass++;
    run_seq("after_stall", 16'h0030, 16'h0033, 0, 1'b0);
  endtask
`endif

  initial begin
    bus.start = 1'b0; bus.start_val = '0; bus.target = '0; bus.pause = 1'b0;
    rst_ = 1'b1;
    test_reset();
    test_count_up();
    test_count_down();
    test_pause();
    test_reset_in_run();
    test_back_to_back();
    test_random();
`ifdef SEQ_STALL_DET_EN
    test_stall();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
